// File: rtl/abc_chk_pkg.sv
// Shared types and helpers for the result checker of the a & (b | c) block.
package abc_chk_pkg;

  localparam int NUM_BINS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } abc_state_t;

  // Golden model of the block under test.
  function automatic logic exp_z(input logic a, input logic b, input logic c);
    return a & (b | c);
  endfunction

  // Coverage bin index of an input vector.
  function automatic logic [2:0] bin_idx(input logic a, input logic b, input logic c);
    return {a, b, c};
  endfunction

endpackage

// File: rtl/abc_result_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins over increment; increment holds once all-ones is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/abc_result_checker.sv
// Self-checking stage behind the 3-input logic block: accepts {a,b,c,z},
// compares z with the golden model one cycle later, counts tests/errors,
// tracks coverage of all eight input combinations and gives a verdict.
module abc_result_checker
  import abc_chk_pkg::*;
#(
  parameter int                     CNT_W     = 16,
  parameter logic [NUM_BINS-1:0]    BIN_MASK  = 8'hFF,
  parameter bit                     AUTO_STOP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_a,
  input  logic                in_b,
  input  logic                in_c,
  input  logic                dut_z,
  output logic [CNT_W-1:0]    test_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [NUM_BINS-1:0] bin_hit,
  output logic                cov_done,
  output logic                first_err_valid,
  output logic [2:0]          first_err_vec,
  output logic                busy,
  output logic                pass,
  output logic                fail
);

  abc_state_t state, state_next;

  logic accept;
  logic s1_vld;
  logic s1_a, s1_b, s1_c, s1_z;
  logic chk;
  logic mismatch;
  logic pass_next;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign cov_done = ((bin_hit & BIN_MASK) == BIN_MASK);

  // A start cycle never accepts a vector, and a vector already in the
  // pipeline when start arrives is discarded rather than counted.
  assign accept   = in_valid && in_ready && !start;
  assign chk      = s1_vld && !start;
  assign mismatch = (s1_z != exp_z(s1_a, s1_b, s1_c));

  // The verdict looks at the counts as they will be after this edge, so a
  // vector checked on the DRAIN->DONE edge is already reflected in it.
  assign pass_next = ((err_cnt == '0) && !(chk && mismatch)) &&
                     ((test_cnt != '0) || chk);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Session sequencing; start restarts from any state and beats stop.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (stop || (AUTO_STOP && cov_done)) state_next = DRAIN;
        DRAIN:   state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // First pipeline stage: capture the accepted vector and the DUT's answer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_a   <= 1'b0;
      s1_b   <= 1'b0;
      s1_c   <= 1'b0;
      s1_z   <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_c <= in_c;
        s1_z <= dut_z;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_test_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .inc (chk),
    .q   (test_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .inc (chk && mismatch),
    .q   (err_cnt)
  );

  // Sticky coverage bins, cleared at the start of each session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_hit <= '0;
    end else if (start) begin
      bin_hit <= '0;
    end else if (chk) begin
      bin_hit[bin_idx(s1_a, s1_b, s1_c)] <= 1'b1;
    end
  end

  // Capture only the first mismatching vector of the session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'b000;
    end else if (start) begin
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'b000;
    end else if (chk && mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_vec   <= bin_idx(s1_a, s1_b, s1_c);
    end
  end

  // Verdict is registered on entry to DONE and is zero in every other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      pass <= (state_next == DONE) && pass_next;
      fail <= (state_next == DONE) && !pass_next;
    end
  end

endmodule

// File: tb/tb_abc_result_checker.sv
// Bench for abc_result_checker (CNT_W=4 to reach saturation, AUTO_STOP=1).
// Directed steps from the test plan followed by a randomized session mix,
// all compared against a session-level reference model.
module tb_abc_result_checker;

  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, in_valid, in_a, in_b, in_c, dut_z;
  logic       in_ready;
  logic [CNT_W-1:0] test_cnt, err_cnt;
  logic [7:0] bin_hit;
  logic       cov_done, first_err_valid, busy, pass, fail;
  logic [2:0] first_err_vec;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state.
  int       m_phase;
  int       m_test, m_err;
  bit [7:0] m_bins;
  bit       m_fe_v;
  bit [2:0] m_fe_vec;
  bit       m_pass, m_fail;
  int       m_q[$];

  abc_result_checker #(
    .CNT_W     (CNT_W),
    .BIN_MASK  (8'hFF),
    .AUTO_STOP (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stop            (stop),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_c            (in_c),
    .dut_z           (dut_z),
    .test_cnt        (test_cnt),
    .err_cnt         (err_cnt),
    .bin_hit         (bin_hit),
    .cov_done        (cov_done),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .busy            (busy),
    .pass            (pass),
    .fail            (fail)
  );

  always #5 clk = ~clk;

  // Truth table of the upstream block: only vectors 101, 110, 111 give 1.
  function automatic bit golden(input int vec);
    return (vec == 5) || (vec == 6) || (vec == 7);
  endfunction

  task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    m_test   = 0;
    m_err    = 0;
    m_bins   = 8'h00;
    m_fe_v   = 1'b0;
    m_fe_vec = 3'b000;
    m_pass   = 1'b0;
    m_fail   = 1'b0;
    m_q.delete();
  endtask

  task automatic modelReset();
    modelClear();
    m_phase = P_IDLE;
  endtask

  // What one clock edge does to the session, given the sampled inputs.
  task automatic modelEdge(input bit st, input bit sp, input bit v, input int vec, input bit z);
    bit ready;
    bit all_covered;
    int e;
    ready       = (m_phase == P_RUN);
    all_covered = (m_bins == 8'hFF);
    if (st) begin
      modelClear();
      m_phase = P_RUN;
    end else begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (m_test < MAXC) m_test = m_test + 1;
        if ((e & 1) != int'(golden(e >> 1))) begin
          if (m_err < MAXC) m_err = m_err + 1;
          if (!m_fe_v) begin
            m_fe_v   = 1'b1;
            m_fe_vec = 3'(e >> 1);
          end
        end
        m_bins[e >> 1] = 1'b1;
      end
      if (v && ready) m_q.push_back((vec << 1) | int'(z));
      if (m_phase == P_RUN && (sp || all_covered)) m_phase = P_DRAIN;
      else if (m_phase == P_DRAIN) m_phase = P_DONE;
    end
    m_pass = (m_phase == P_DONE) && (m_err == 0) && (m_test != 0);
    m_fail = (m_phase == P_DONE) && !((m_err == 0) && (m_test != 0));
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".test_cnt"}, 16'(test_cnt), 16'(m_test));
    checkOne({tag, ".err_cnt"}, 16'(err_cnt), 16'(m_err));
    checkOne({tag, ".bin_hit"}, 16'(bin_hit), 16'(m_bins));
    checkOne({tag, ".cov_done"}, 16'(cov_done), 16'(m_bins == 8'hFF));
    checkOne({tag, ".fe_valid"}, 16'(first_err_valid), 16'(m_fe_v));
    checkOne({tag, ".fe_vec"}, 16'(first_err_vec), 16'(m_fe_vec));
    checkOne({tag, ".busy"}, 16'(busy), 16'((m_phase == P_RUN) || (m_phase == P_DRAIN)));
    checkOne({tag, ".in_ready"}, 16'(in_ready), 16'(m_phase == P_RUN));
    checkOne({tag, ".pass"}, 16'(pass), 16'(m_pass));
    checkOne({tag, ".fail"}, 16'(fail), 16'(m_fail));
  endtask

  // Drive one cycle of inputs on the falling edge, advance the model on the
  // rising edge and compare just after it.
  task automatic applyStimulus(input string tag, input bit st, input bit sp, input bit v,
                               input int vec, input bit z);
    @(negedge clk);
    start    = st;
    stop     = sp;
    in_valid = v;
    in_a     = vec[2];
    in_b     = vec[1];
    in_c     = vec[0];
    dut_z    = z;
    @(posedge clk);
    modelEdge(st, sp, v, vec, z);
    #1;
    checkOutput(tag);
  endtask

  task automatic sendVec(input string tag, input int vec, input bit correct);
    applyStimulus(tag, 1'b0, 1'b0, 1'b1, vec, correct ? golden(vec) : !golden(vec));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic midClockReset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int plan[5];
    int vec;
    bit st, sp, v, z;
    plan = '{0, 3, 6, 5, 4};

    rst = 1'b1;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    in_a = 1'b0; in_b = 1'b0; in_c = 1'b0; dut_z = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] plan 1: correct vectors, manual stop");
    applyStimulus("p1.start", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) sendVec("p1.vec", plan[i], 1'b1);
    applyStimulus("p1.stop", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle("p1.drain", 1);
    checkOne("p1.const_test", 16'(test_cnt), 16'd5);
    checkOne("p1.const_bins", 16'(bin_hit), 16'h0079);
    checkOne("p1.const_pass", 16'(pass), 16'd1);

    $display("[TB] plan 2: wrong z on 101");
    applyStimulus("p2.start", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) sendVec("p2.vec", plan[i], plan[i] != 5);
    applyStimulus("p2.stop", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle("p2.drain", 1);
    checkOne("p2.const_err", 16'(err_cnt), 16'd1);
    checkOne("p2.const_fevec", 16'(first_err_vec), 16'd5);
    checkOne("p2.const_fail", 16'(fail), 16'd1);

    $display("[TB] plan 3: full coverage auto stop");
    applyStimulus("p3.start", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) sendVec("p3.vec", i, 1'b1);
    idle("p3.tail", 4);
    checkOne("p3.const_test", 16'(test_cnt), 16'd8);
    checkOne("p3.const_cov", 16'(cov_done), 16'd1);
    checkOne("p3.const_pass", 16'(pass), 16'd1);

    $display("[TB] plan 4: saturation");
    applyStimulus("p4.start", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 17; i++) sendVec("p4.vec", int'($urandom_range(6, 0)), 1'b0);
    applyStimulus("p4.stop", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle("p4.drain", 2);
    checkOne("p4.const_test", 16'(test_cnt), 16'h000F);
    checkOne("p4.const_err", 16'(err_cnt), 16'h000F);

    $display("[TB] plan 5: reset mid-session");
    applyStimulus("p5.start", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) sendVec("p5.vec", i + 1, 1'b1);
    midClockReset("p5.rst");
    applyStimulus("p5.restart", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOne("p5.const_test", 16'(test_cnt), 16'd0);

    $display("[TB] plan 6: start priority");
    applyStimulus("p6.stop", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle("p6.drain", 2);
    applyStimulus("p6.start_vld", 1'b1, 1'b0, 1'b1, 7, 1'b1);
    idle("p6.after", 1);
    checkOne("p6.const_test", 16'(test_cnt), 16'd0);
    sendVec("p6.vec", 2, 1'b1);
    sendVec("p6.vec", 3, 1'b1);
    applyStimulus("p6.start_stop", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    idle("p6.stay", 1);
    checkOne("p6.const_ready", 16'(in_ready), 16'd1);
    checkOne("p6.const_test2", 16'(test_cnt), 16'd0);

    $display("[TB] randomized sessions");
    for (int i = 0; i < 400; i++) begin
      if (m_phase == P_IDLE || m_phase == P_DONE) st = ($urandom_range(4, 0) == 0);
      else st = ($urandom_range(39, 0) == 0);
      sp  = ($urandom_range(24, 0) == 0);
      v   = ($urandom_range(3, 0) != 0);
      vec = int'($urandom_range(7, 0));
      z   = ($urandom_range(9, 0) < 8) ? golden(vec) : !golden(vec);
      applyStimulus("rnd", st, sp, v, vec, z);
      if (i == 200) midClockReset("rnd.rst");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/abc_result_checker.md
Name: abc_result_checker

Overview:
Hardware self-checking stage directly downstream of the 3-input logic block `top` (z = a & (b | c)).
- Consumes each applied {a,b,c} vector together with the DUT's z through a valid/ready handshake.
- Compares z against a golden model and keeps saturating test and error counters.
- Tracks functional coverage of all 8 input combinations and reports a pass/fail verdict at session end.

Parameters:
- CNT_W, 16, width of the test and error counters.
- BIN_MASK, 8'hFF, coverage goal; bit i is required bin {a,b,c}==i.
- AUTO_STOP, 1, when 1 the session ends on its own once every masked bin is hit.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; clears all results and opens a session.
- stop  in  1  pulse; ends the session.
- in_valid  in  1  vector and z present.
- in_ready  out  1  checker accepts a vector.
- in_a, in_b, in_c  in  1 each  vector applied to the DUT.
- dut_z  in  1  DUT output for that vector.
- test_cnt  out  CNT_W  number of vectors checked.
- err_cnt  out  CNT_W  number of mismatches.
- bin_hit  out  8  sticky coverage bins.
- cov_done  out  1  (bin_hit & BIN_MASK) == BIN_MASK.
- first_err_valid  out  1  a mismatch has been captured.
- first_err_vec  out  3  {a,b,c} of the first mismatch.
- busy  out  1  state is RUN or DRAIN.
- pass  out  1  verdict: pass.
- fail  out  1  verdict: fail.

Behaviour:
- Reset (asynchronous, any time, including mid-session): state=IDLE and every output is 0. This includes counters, bins, first_err_*, pass, fail and in_ready. The pipeline valid bit is cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -start-> RUN.
  - RUN -stop, or (AUTO_STOP & cov_done)-> DRAIN.
  - DRAIN -> DONE unconditionally after 1 cycle.
  - DONE -start-> RUN.
  - start in RUN or DRAIN restarts: results are cleared and the state goes to RUN.
- start clears test_cnt, err_cnt, bin_hit, first_err_* and the verdict on the same edge it is sampled.
- start has priority over stop and over a concurrent accept. A vector presented in the start cycle is not counted.
- in_ready = 1 only in RUN. A vector is accepted on an edge where in_valid & in_ready.
- Pipeline, 2 stages:
  - Accept edge k registers {a,b,c,z} and s1_vld.
  - Edge k+1 evaluates exp = a & (b | c) from the registered values and updates the results.
  - Result outputs change after edge k+1; latency is 1 cycle from accept.
- DRAIN exists so that a vector accepted on the last RUN edge is still counted before DONE.
- Each checked vector:
  - test_cnt increments.
  - err_cnt increments if z != exp.
  - bin_hit[{a,b,c}] is set.
  - On the first mismatch of the session, first_err_vec is captured and first_err_valid is set. Both hold until start or reset.
- Counters saturate at all-ones and never wrap.
- cov_done is combinational from registered bin_hit and BIN_MASK.
- On entry to DONE (registered, valid while in DONE):
  - pass = (err_cnt == 0) & (test_cnt != 0).
  - fail = !pass.
  - Both are 0 in all other states.
- A stop pulse in IDLE or DONE is ignored.
- in_valid while in_ready = 0 is dropped; there is no buffering.

Decomposition:
- Package abc_chk_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - the golden function exp_z(a,b,c);
  - the bin-index helper {a,b,c};
  - the constant NUM_BINS = 8.
- Sub-module: sat_counter (parameter W; ports clr, inc, q). It is instantiated twice, for test_cnt and err_cnt.

Test Plan:
1. Correct DUT, AUTO_STOP=0: start, apply 000, 011, 110, 101, 100 with correct z, then stop -> test_cnt=5, err_cnt=0, bin_hit=8'b0111_1001, cov_done=0, DONE with pass=1.
2. Fault injection: the same sequence but drive z=0 for 101 (expected 1) -> err_cnt=1, first_err_valid=1, first_err_vec=3'b101, fail=1.
3. AUTO_STOP=1: all 8 vectors back-to-back with correct z -> after the 8th is checked, in_ready drops, DRAIN then DONE. test_cnt=8, bin_hit=8'hFF, cov_done=1, pass=1.
4. Saturation, CNT_W=4: 17 accepted vectors each with wrong z -> test_cnt=4'hF, err_cnt=4'hF, with no wrap.
5. Reset mid-operation: assert rst asynchronously after 3 accepted vectors (mid-clock) -> all outputs are 0 immediately and state is IDLE. The next start gives test_cnt=0.
6. Priority: in DONE, assert start with in_valid=1 in the same cycle -> that vector is not counted, results clear, state is RUN. In RUN, start together with stop -> the session restarts and stays in RUN.
